// File: rtl/alu_design.sv
// -----------------------------------------------------------------------------
// alu_design -- registered N-bit arithmetic/logic unit with flag outputs.
//
// Purpose
//   Samples operands and opcode on a rising CLK edge with CE=1 and presents
//   the result and flags on that same edge (registered outputs). Multiply
//   opcodes take one extra CE=1 edge: operands are captured on the accepting
//   edge, and the product is issued on the next enabled edge. Inputs present
//   during that second edge are ignored.
//
// Configuration
//   ALU_MULT_EN : when defined, arithmetic opcodes 9 (MUL_INC) and 10 (MUL_SHL)
//                 are implemented with a 2-cycle latency. When undefined, they
//                 are undefined opcodes (ERR=1, RES=0, 1-cycle latency) and no
//                 multiplier is built.
//
// Parameters
//   N          : operand width in bits (power of two, >= 4)
//
// Ports
//   CLK        : clock, all state changes on the rising edge
//   RST        : asynchronous active-high reset, has priority over CE
//   CE         : clock enable, 0 holds all outputs and internal state
//   MODE       : 1 = arithmetic, 0 = logical
//   CMD[3:0]   : opcode
//   OPA, OPB   : N-bit operands
//   CIN        : carry/borrow in
//   INP_VALID  : bit0 = OPA valid, bit1 = OPB valid
//   RES        : 2N-bit registered result, zero-extended
//   COUT       : carry out of bit N-1 (ADD, ADD_CIN)
//   OFLOW      : borrow (SUB, SUB_CIN, DEC_A, DEC_B)
//   G, L, E    : compare greater / less / equal (CMP)
//   ERR        : undefined opcode, missing operand or out-of-range rotate
// -----------------------------------------------------------------------------
module alu_design #(
    parameter int N = 8
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           CE,
    input  logic           MODE,
    input  logic [3:0]     CMD,
    input  logic [N-1:0]   OPA,
    input  logic [N-1:0]   OPB,
    input  logic           CIN,
    input  logic [1:0]     INP_VALID,
    output logic [2*N-1:0] RES,
    output logic           COUT,
    output logic           OFLOW,
    output logic           G,
    output logic           L,
    output logic           E,
    output logic           ERR
);

    localparam int LG = $clog2(N);

    // Arithmetic opcodes (MODE = 1)
    localparam logic [3:0] A_ADD     = 4'd0;
    localparam logic [3:0] A_SUB     = 4'd1;
    localparam logic [3:0] A_ADD_CIN = 4'd2;
    localparam logic [3:0] A_SUB_CIN = 4'd3;
    localparam logic [3:0] A_INC_A   = 4'd4;
    localparam logic [3:0] A_DEC_A   = 4'd5;
    localparam logic [3:0] A_INC_B   = 4'd6;
    localparam logic [3:0] A_DEC_B   = 4'd7;
    localparam logic [3:0] A_CMP     = 4'd8;
    localparam logic [3:0] A_MUL_INC = 4'd9;
    localparam logic [3:0] A_MUL_SHL = 4'd10;

    // Logical opcodes (MODE = 0)
    localparam logic [3:0] L_AND     = 4'd0;
    localparam logic [3:0] L_NAND    = 4'd1;
    localparam logic [3:0] L_OR      = 4'd2;
    localparam logic [3:0] L_NOR     = 4'd3;
    localparam logic [3:0] L_XOR     = 4'd4;
    localparam logic [3:0] L_XNOR    = 4'd5;
    localparam logic [3:0] L_NOT_A   = 4'd6;
    localparam logic [3:0] L_NOT_B   = 4'd7;
    localparam logic [3:0] L_SHR1_A  = 4'd8;
    localparam logic [3:0] L_SHL1_A  = 4'd9;
    localparam logic [3:0] L_SHR1_B  = 4'd10;
    localparam logic [3:0] L_SHL1_B  = 4'd11;
    localparam logic [3:0] L_ROL     = 4'd12;
    localparam logic [3:0] L_ROR     = 4'd13;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t         state_r;
    state_t         state_s;

    logic [2*N-1:0] res_r;
    logic           cout_r;
    logic           oflow_r;
    logic           g_r;
    logic           l_r;
    logic           e_r;
    logic           err_r;

    logic [2*N-1:0] res_s;
    logic           cout_s;
    logic           oflow_s;
    logic           g_s;
    logic           l_s;
    logic           e_s;
    logic           err_s;

    logic           need_a_s;
    logic           need_b_s;
    logic           undef_s;
    logic           opnd_err_s;
    logic           rot_range_err_s;
    logic [N:0]     wide_s;

`ifdef ALU_MULT_EN
    // Captured multiplier factors, N+1 bits so (A+1) never loses its carry
    logic [N:0]     mul_a_r;
    logic [N:0]     mul_b_r;
    logic [N:0]     mul_a_s;
    logic [N:0]     mul_b_s;
    logic [2*N-1:0] mul_prod_s;
`endif

    // Rotate left; N is a power of two so the index wraps by truncation
    function automatic logic [N-1:0] rotl(input logic [N-1:0] a, input logic [LG-1:0] amt);
        logic [N-1:0] r;
        logic [LG-1:0] idx;
        r = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            idx    = LG'(i) + amt;
            r[idx] = a[i];
        end
        return r;
    endfunction

    // Rotate right; bit i of the result comes from bit i+amt (mod N)
    function automatic logic [N-1:0] rotr(input logic [N-1:0] a, input logic [LG-1:0] amt);
        logic [N-1:0] r;
        logic [LG-1:0] idx;
        r = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            idx  = LG'(i) + amt;
            r[i] = a[idx];
        end
        return r;
    endfunction

    // Zero-extend an N-bit logical/wrapped result to the 2N-bit result bus
    function automatic logic [2*N-1:0] zext(input logic [N-1:0] v);
        return {{N{1'b0}}, v};
    endfunction

`ifdef ALU_MULT_EN
    // Product of the captured factors, truncated to the 2N-bit result bus
    always_comb begin
        mul_prod_s = {{(N-1){1'b0}}, mul_a_r} * {{(N-1){1'b0}}, mul_b_r};
    end
`endif

    // Opcode classification: which operands are needed and which codes are undefined
    always_comb begin
        need_a_s = 1'b1;
        need_b_s = 1'b1;
        undef_s  = 1'b0;
        if (MODE) begin
            case (CMD)
                A_ADD, A_SUB, A_ADD_CIN, A_SUB_CIN, A_CMP: begin
                    need_a_s = 1'b1;
                    need_b_s = 1'b1;
                end
                A_INC_A, A_DEC_A: begin
                    need_b_s = 1'b0;
                end
                A_INC_B, A_DEC_B: begin
                    need_a_s = 1'b0;
                end
                A_MUL_INC, A_MUL_SHL: begin
`ifdef ALU_MULT_EN
                    undef_s = 1'b0;
`else
                    undef_s = 1'b1;
`endif
                end
                default: begin
                    undef_s = 1'b1;
                end
            endcase
        end else begin
            case (CMD)
                L_AND, L_NAND, L_OR, L_NOR, L_XOR, L_XNOR, L_ROL, L_ROR: begin
                    need_a_s = 1'b1;
                    need_b_s = 1'b1;
                end
                L_NOT_A, L_SHR1_A, L_SHL1_A: begin
                    need_b_s = 1'b0;
                end
                L_NOT_B, L_SHR1_B, L_SHL1_B: begin
                    need_a_s = 1'b0;
                end
                default: begin
                    undef_s = 1'b1;
                end
            endcase
        end
    end

    // Operand-missing and rotate-range error terms
    always_comb begin
        opnd_err_s      = (need_a_s & ~INP_VALID[0]) | (need_b_s & ~INP_VALID[1]);
        // Bit LG of OPB is deliberately outside the checked range
        rot_range_err_s = |(OPB >> (LG + 1));
    end

    // Next-state and next-output logic
    always_comb begin
        state_s = state_r;
        res_s   = {(2*N){1'b0}};
        cout_s  = 1'b0;
        oflow_s = 1'b0;
        g_s     = 1'b0;
        l_s     = 1'b0;
        e_s     = 1'b0;
        err_s   = 1'b0;
        wide_s  = {(N+1){1'b0}};
`ifdef ALU_MULT_EN
        mul_a_s = mul_a_r;
        mul_b_s = mul_b_r;
`endif
        if (state_r == ST_MUL) begin
            // Second multiply edge: issue the product, ignore current inputs
`ifdef ALU_MULT_EN
            res_s = mul_prod_s;
`else
            res_s = {(2*N){1'b0}};
`endif
            state_s = ST_IDLE;
        end else if (undef_s || opnd_err_s) begin
            err_s = 1'b1;
        end else if (MODE) begin
            case (CMD)
                A_ADD: begin
                    wide_s = {1'b0, OPA} + {1'b0, OPB};
                    res_s  = {{(N-1){1'b0}}, wide_s};
                    cout_s = wide_s[N];
                end
                A_ADD_CIN: begin
                    wide_s = {1'b0, OPA} + {1'b0, OPB} + {{N{1'b0}}, CIN};
                    res_s  = {{(N-1){1'b0}}, wide_s};
                    cout_s = wide_s[N];
                end
                A_SUB: begin
                    // Bit N of the N+1-bit difference is the borrow
                    wide_s  = {1'b0, OPA} - {1'b0, OPB};
                    res_s   = zext(wide_s[N-1:0]);
                    oflow_s = wide_s[N];
                end
                A_SUB_CIN: begin
                    wide_s  = {1'b0, OPA} - {1'b0, OPB} - {{N{1'b0}}, CIN};
                    res_s   = zext(wide_s[N-1:0]);
                    oflow_s = wide_s[N];
                end
                A_INC_A: begin
                    wide_s = {1'b0, OPA} + {{N{1'b0}}, 1'b1};
                    res_s  = zext(wide_s[N-1:0]);
                end
                A_DEC_A: begin
                    wide_s  = {1'b0, OPA} - {{N{1'b0}}, 1'b1};
                    res_s   = zext(wide_s[N-1:0]);
                    oflow_s = wide_s[N];
                end
                A_INC_B: begin
                    wide_s = {1'b0, OPB} + {{N{1'b0}}, 1'b1};
                    res_s  = zext(wide_s[N-1:0]);
                end
                A_DEC_B: begin
                    wide_s  = {1'b0, OPB} - {{N{1'b0}}, 1'b1};
                    res_s   = zext(wide_s[N-1:0]);
                    oflow_s = wide_s[N];
                end
                A_CMP: begin
                    e_s = (OPA == OPB);
                    g_s = (OPA > OPB);
                    l_s = (OPA < OPB);
                end
`ifdef ALU_MULT_EN
                A_MUL_INC: begin
                    // Outputs read zero on the accepting edge
                    mul_a_s = {1'b0, OPA} + {{N{1'b0}}, 1'b1};
                    mul_b_s = {1'b0, OPB} + {{N{1'b0}}, 1'b1};
                    state_s = ST_MUL;
                end
                A_MUL_SHL: begin
                    mul_a_s = {1'b0, OPA[N-2:0], 1'b0};
                    mul_b_s = {1'b0, OPB};
                    state_s = ST_MUL;
                end
`endif
                default: begin
                    err_s = 1'b1;
                end
            endcase
        end else begin
            case (CMD)
                L_AND:    res_s = zext(OPA & OPB);
                L_NAND:   res_s = zext(~(OPA & OPB));
                L_OR:     res_s = zext(OPA | OPB);
                L_NOR:    res_s = zext(~(OPA | OPB));
                L_XOR:    res_s = zext(OPA ^ OPB);
                L_XNOR:   res_s = zext(~(OPA ^ OPB));
                L_NOT_A:  res_s = zext(~OPA);
                L_NOT_B:  res_s = zext(~OPB);
                L_SHR1_A: res_s = zext({1'b0, OPA[N-1:1]});
                L_SHL1_A: res_s = zext({OPA[N-2:0], 1'b0});
                L_SHR1_B: res_s = zext({1'b0, OPB[N-1:1]});
                L_SHL1_B: res_s = zext({OPB[N-2:0], 1'b0});
                L_ROL: begin
                    res_s = zext(rotl(OPA, OPB[LG-1:0]));
                    err_s = rot_range_err_s;
                end
                L_ROR: begin
                    res_s = zext(rotr(OPA, OPB[LG-1:0]));
                    err_s = rot_range_err_s;
                end
                default: begin
                    err_s = 1'b1;
                end
            endcase
        end
    end

    // State, operand capture and output registers; CE=0 holds everything
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
            res_r   <= {(2*N){1'b0}};
            cout_r  <= 1'b0;
            oflow_r <= 1'b0;
            g_r     <= 1'b0;
            l_r     <= 1'b0;
            e_r     <= 1'b0;
            err_r   <= 1'b0;
`ifdef ALU_MULT_EN
            mul_a_r <= {(N+1){1'b0}};
            mul_b_r <= {(N+1){1'b0}};
`endif
        end else if (CE) begin
            state_r <= state_s;
            res_r   <= res_s;
            cout_r  <= cout_s;
            oflow_r <= oflow_s;
            g_r     <= g_s;
            l_r     <= l_s;
            e_r     <= e_s;
            err_r   <= err_s;
`ifdef ALU_MULT_EN
            mul_a_r <= mul_a_s;
            mul_b_r <= mul_b_s;
`endif
        end
    end

    assign RES   = res_r;
    assign COUT  = cout_r;
    assign OFLOW = oflow_r;
    assign G     = g_r;
    assign L     = l_r;
    assign E     = e_r;
    assign ERR   = err_r;

endmodule

// File: tb/tb_alu_design.sv
// -----------------------------------------------------------------------------
// tb_alu_design -- directed self-checking bench for alu_design (N = 8).
// Inputs change on the falling edge; outputs are checked on the following
// falling edge, half a cycle after the rising edge that registered them.
// Multiply vectors are selected by ALU_MULT_EN, matching the DUT build.
// -----------------------------------------------------------------------------
module tb_alu_design;

    localparam int N = 8;

    localparam logic [5:0] F_NONE = 6'b000000;
    localparam logic [5:0] F_COUT = 6'b100000;
    localparam logic [5:0] F_OFL  = 6'b010000;
    localparam logic [5:0] F_G    = 6'b001000;
    localparam logic [5:0] F_L    = 6'b000100;
    localparam logic [5:0] F_E    = 6'b000010;
    localparam logic [5:0] F_ERR  = 6'b000001;

    logic           CLK = 1'b0;
    logic           RST;
    logic           CE;
    logic           MODE;
    logic [3:0]     CMD;
    logic [N-1:0]   OPA;
    logic [N-1:0]   OPB;
    logic           CIN;
    logic [1:0]     INP_VALID;
    logic [2*N-1:0] RES;
    logic           COUT;
    logic           OFLOW;
    logic           G;
    logic           L;
    logic           E;
    logic           ERR;
    logic [5:0]     flags;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    assign flags = {COUT, OFLOW, G, L, E, ERR};

    alu_design #(.N(N)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .CE        (CE),
        .MODE      (MODE),
        .CMD       (CMD),
        .OPA       (OPA),
        .OPB       (OPB),
        .CIN       (CIN),
        .INP_VALID (INP_VALID),
        .RES       (RES),
        .COUT      (COUT),
        .OFLOW     (OFLOW),
        .G         (G),
        .L         (L),
        .E         (E),
        .ERR       (ERR)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [15:0] res, input logic [5:0] fl);
        check_val({tag, ".res"}, {16'h0000, RES}, {16'h0000, res});
        check_val({tag, ".flags"}, {26'h0, flags}, {26'h0, fl});
    endtask

    task automatic apply(input logic mode, input logic [3:0] cmd, input logic [7:0] a,
                         input logic [7:0] b, input logic cin, input logic [1:0] vld);
        CE        = 1'b1;
        MODE      = mode;
        CMD       = cmd;
        OPA       = a;
        OPB       = b;
        CIN       = cin;
        INP_VALID = vld;
    endtask

    task automatic step;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        RST = 1'b1; CE = 1'b0; MODE = 1'b0; CMD = 4'd0;
        OPA = 8'h00; OPB = 8'h00; CIN = 1'b0; INP_VALID = 2'b00;
        repeat (2) @(negedge CLK);
        expect_out("reset", 16'h0000, F_NONE);
        RST = 1'b0;

        // Arithmetic
        apply(1'b1, 4'd0, 8'hFF, 8'h01, 1'b0, 2'b11); step; expect_out("add_carry", 16'h0100, F_COUT);
        apply(1'b1, 4'd1, 8'h05, 8'h07, 1'b0, 2'b11); step; expect_out("sub_borrow", 16'h00FE, F_OFL);
        apply(1'b1, 4'd8, 8'h33, 8'h33, 1'b0, 2'b11); step; expect_out("cmp_eq", 16'h0000, F_E);
        apply(1'b1, 4'd8, 8'h40, 8'h30, 1'b0, 2'b11); step; expect_out("cmp_gt", 16'h0000, F_G);
        apply(1'b1, 4'd8, 8'h10, 8'h20, 1'b0, 2'b11); step; expect_out("cmp_lt", 16'h0000, F_L);
        apply(1'b1, 4'd2, 8'h7F, 8'h80, 1'b1, 2'b11); step; expect_out("add_cin", 16'h0100, F_COUT);
        apply(1'b1, 4'd3, 8'h10, 8'h0F, 1'b1, 2'b11); step; expect_out("sub_cin_zero", 16'h0000, F_NONE);
        apply(1'b1, 4'd3, 8'h10, 8'h10, 1'b1, 2'b11); step; expect_out("sub_cin_borrow", 16'h00FF, F_OFL);
        apply(1'b1, 4'd4, 8'hFF, 8'h00, 1'b0, 2'b01); step; expect_out("inc_a_wrap", 16'h0000, F_NONE);
        apply(1'b1, 4'd7, 8'h00, 8'h20, 1'b0, 2'b10); step; expect_out("dec_b", 16'h001F, F_NONE);
        apply(1'b1, 4'd4, 8'h12, 8'h34, 1'b0, 2'b10); step; expect_out("inc_a_noa", 16'h0000, F_ERR);

        // Logical
        apply(1'b0, 4'd0,  8'hF0, 8'h3C, 1'b0, 2'b11); step; expect_out("and", 16'h0030, F_NONE);
        apply(1'b0, 4'd3,  8'hF0, 8'h0F, 1'b0, 2'b11); step; expect_out("nor", 16'h0000, F_NONE);
        apply(1'b0, 4'd4,  8'hA5, 8'hFF, 1'b0, 2'b11); step; expect_out("xor", 16'h005A, F_NONE);
        apply(1'b0, 4'd7,  8'h00, 8'h0F, 1'b0, 2'b10); step; expect_out("not_b", 16'h00F0, F_NONE);
        apply(1'b0, 4'd9,  8'h81, 8'h00, 1'b0, 2'b01); step; expect_out("shl1_a", 16'h0002, F_NONE);
        apply(1'b0, 4'd10, 8'h00, 8'h81, 1'b0, 2'b10); step; expect_out("shr1_b", 16'h0040, F_NONE);
        apply(1'b0, 4'd12, 8'h81, 8'h01, 1'b0, 2'b11); step; expect_out("rol", 16'h0003, F_NONE);
        apply(1'b0, 4'd12, 8'h81, 8'h11, 1'b0, 2'b11); step; expect_out("rol_range", 16'h0003, F_ERR);
        apply(1'b0, 4'd13, 8'h81, 8'h02, 1'b0, 2'b11); step; expect_out("ror", 16'h0060, F_NONE);
        apply(1'b0, 4'd13, 8'h81, 8'h08, 1'b0, 2'b11); step; expect_out("ror_bit3", 16'h0081, F_NONE);
        apply(1'b0, 4'd14, 8'h81, 8'h08, 1'b0, 2'b11); step; expect_out("log_undef", 16'h0000, F_ERR);
        apply(1'b1, 4'd11, 8'h81, 8'h08, 1'b0, 2'b11); step; expect_out("arith_undef", 16'h0000, F_ERR);
        apply(1'b0, 4'd1,  8'h00, 8'h00, 1'b0, 2'b11); step; expect_out("nand_zero", 16'h00FF, F_NONE);

        // Missing operand, then hold with CE=0
        apply(1'b0, 4'd0, 8'hFF, 8'hFF, 1'b0, 2'b01); step; expect_out("and_nob", 16'h0000, F_ERR);
        apply(1'b1, 4'd0, 8'hFF, 8'h01, 1'b0, 2'b11); CE = 1'b0;
        step; expect_out("ce_hold1", 16'h0000, F_ERR);
        step; expect_out("ce_hold2", 16'h0000, F_ERR);

        // Asynchronous reset between clock edges
        CE = 1'b1; step; expect_out("pre_rst", 16'h0100, F_COUT);
        RST = 1'b1; #1; expect_out("rst_async", 16'h0000, F_NONE);
        RST = 1'b0;

`ifdef ALU_MULT_EN
        apply(1'b1, 4'd9, 8'h03, 8'h04, 1'b0, 2'b11); step; expect_out("mul_accept", 16'h0000, F_NONE);
        apply(1'b1, 4'd0, 8'h01, 8'h01, 1'b0, 2'b11); step; expect_out("mul_inc", 16'h0014, F_NONE);
        step; expect_out("after_mul", 16'h0002, F_NONE);
        apply(1'b1, 4'd10, 8'hC3, 8'h02, 1'b0, 2'b11); step;
        CE = 1'b0; OPA = 8'h00; step; expect_out("mul_ce_gap", 16'h0000, F_NONE);
        CE = 1'b1; step; expect_out("mul_shl", 16'h010C, F_NONE);
        apply(1'b1, 4'd9, 8'h03, 8'h04, 1'b0, 2'b01); step; expect_out("mul_nob", 16'h0000, F_ERR);
        // Reset while a multiply is pending must discard it
        apply(1'b1, 4'd0, 8'hFF, 8'h01, 1'b0, 2'b11); step; expect_out("pre_abort", 16'h0100, F_COUT);
        apply(1'b1, 4'd9, 8'h03, 8'h04, 1'b0, 2'b11); step;
        RST = 1'b1; #1; expect_out("mul_rst", 16'h0000, F_NONE);
        RST = 1'b0;
        apply(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 2'b11); step; expect_out("mul_abort1", 16'h0000, F_NONE);
        step; expect_out("mul_abort2", 16'h0000, F_NONE);
`else
        apply(1'b1, 4'd9,  8'h03, 8'h04, 1'b0, 2'b11); step; expect_out("mul_inc_undef", 16'h0000, F_ERR);
        apply(1'b1, 4'd10, 8'hC3, 8'h02, 1'b0, 2'b11); step; expect_out("mul_shl_undef", 16'h0000, F_ERR);
        apply(1'b0, 4'd0,  8'h0F, 8'hFF, 1'b0, 2'b11); step; expect_out("after_undef", 16'h000F, F_NONE);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
